// File: rtl/debounce_bank_if.sv
// debounce_bank_if: raw inputs and debounced level/edge outputs of a debounce bank
interface debounce_bank_if #(parameter int CH = 5);
  logic [CH-1:0] x;
  logic [CH-1:0] level;
  logic [CH-1:0] pos;
  logic [CH-1:0] neg;
  logic [CH-1:0] stable;
  logic any_pos;
  logic any_neg;
  modport master (output x, input level, pos, neg, stable, any_pos, any_neg);
  modport slave (input x, output level, pos, neg, stable, any_pos, any_neg);
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser plus bounce-cancelling qualifier with edge pulses
module debounce_bank #(
  parameter int CH = 5,
  parameter int DELAY = 1000000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT = 1'b0
) (
  input logic clk,
  input logic rst,
  debounce_bank_if.slave bus
);
  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] LAST = CW'(DELAY);
  typedef enum logic {STABLE, WAIT} state_t;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d, pos_q, pos_d, neg_q, neg_d, s;
    assign s = sync_q[SYNC_STAGES-1];
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.x[i]};
      state_d = state_q;
      cnt_d = '0;
      level_d = level_q;
      pos_d = 1'b0;
      neg_d = 1'b0;
      if (state_q == STABLE) begin
        state_d = (s != level_q) ? WAIT : STABLE;
        cnt_d = (s != level_q) ? CW'(1) : '0;
      end else if (s == level_q) begin
        state_d = STABLE;
      end else if (cnt_q == LAST) begin
        // accepted change: pulse aligns with the first cycle of the new level
        state_d = STABLE;
        level_d = ~level_q;
        pos_d = ~level_q;
        neg_d = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{INIT}};
        state_q <= STABLE;
        cnt_q <= '0;
        level_q <= INIT;
        pos_q <= 1'b0;
        neg_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        state_q <= state_d;
        cnt_q <= cnt_d;
        level_q <= level_d;
        pos_q <= pos_d;
        neg_q <= neg_d;
      end
    end
    assign bus.level[i] = level_q;
    assign bus.pos[i] = pos_q;
    assign bus.neg[i] = neg_q;
    assign bus.stable[i] = (state_q == STABLE);
  end
  assign bus.any_pos = |bus.pos;
  assign bus.any_neg = |bus.neg;
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed checks of a 4-channel bank (DELAY=4) plus an INIT=1 instance
module tb_debounce_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  debounce_bank_if #(.CH(4)) if0 ();
  debounce_bank_if #(.CH(4)) if1 ();
  debounce_bank #(.CH(4), .DELAY(4), .SYNC_STAGES(2), .INIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  debounce_bank #(.CH(4), .DELAY(4), .SYNC_STAGES(2), .INIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  always #5 clk = ~clk;
  logic [17:0] got0, got1, exp;
  assign got0 = {if0.level, if0.pos, if0.neg, if0.stable, if0.any_pos, if0.any_neg};
  assign got1 = {if1.level, if1.pos, if1.neg, if1.stable, if1.any_pos, if1.any_neg};
  assign if1.x = 4'b0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.x = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      exp = {4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0};
      n_vec++;
      if (got0 !== exp) begin
        n_err++;
        $display("FAIL reset_idle j=%0d got=%h exp=%h", j, got0, exp);
      end
    end
  endtask

  task automatic test_step();
    if0.x = 4'b0001;
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp = {3'b000, j >= 7, 3'b000, j == 7, 4'b0000,
             3'b111, !(j >= 3 && j <= 6), j == 7, 1'b0};
      n_vec++;
      if (got0 !== exp) begin
        n_err++;
        $display("FAIL clean_step j=%0d got=%h exp=%h", j, got0, exp);
      end
    end
  endtask

  task automatic test_bounce();
    if0.x = 4'b0011;
    for (int j = 1; j <= 16; j++) begin
      tick();
      exp = {2'b00, j >= 11, 1'b1, 2'b00, j == 11, 1'b0, 4'b0000,
             2'b11, !((j >= 3 && j <= 5) || (j >= 7 && j <= 10)), 1'b1, j == 11, 1'b0};
      n_vec++;
      if (got0 !== exp) begin
        n_err++;
        $display("FAIL bounce j=%0d got=%h exp=%h", j, got0, exp);
      end
      if (j == 3) if0.x = 4'b0001;
      if (j == 4) if0.x = 4'b0011;
    end
  endtask

  task automatic test_simultaneous();
    if0.x = 4'b1011;
    for (int j = 1; j <= 10; j++) tick();
    n_vec++;
    if (if0.level !== 4'b1011) begin
      n_err++;
      $display("FAIL simul_setup got=%b exp=1011", if0.level);
    end
    if0.x = 4'b0111;
    for (int j = 1; j <= 10; j++) begin
      tick();
      exp = {j < 7, j >= 7, 2'b11, 1'b0, j == 7, 2'b00, j == 7, 3'b000,
             {2{!(j >= 3 && j <= 6)}}, 2'b11, j == 7, j == 7};
      n_vec++;
      if (got0 !== exp) begin
        n_err++;
        $display("FAIL simultaneous j=%0d got=%h exp=%h", j, got0, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    if0.x = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    if0.x = 4'b0001;
    for (int j = 1; j <= 5; j++) begin
      tick();
      exp = {4'b0000, 4'b0000, 4'b0000, 3'b111, !(j >= 3), 1'b0, 1'b0};
      n_vec++;
      if (got0 !== exp) begin
        n_err++;
        $display("FAIL mid_qualify j=%0d got=%h exp=%h", j, got0, exp);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp = {4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0};
    n_vec++;
    if (got0 !== exp) begin
      n_err++;
      $display("FAIL mid_reset got=%h exp=%h", got0, exp);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = {3'b000, k >= 7, 3'b000, k == 7, 4'b0000,
             3'b111, !(k >= 3 && k <= 6), k == 7, 1'b0};
      n_vec++;
      if (got0 !== exp) begin
        n_err++;
        $display("FAIL mid_requalify k=%0d got=%h exp=%h", k, got0, exp);
      end
    end
  endtask

  task automatic test_init_one();
    rst = 1'b1;
    if0.x = 4'b0000;
    tick();
    tick();
    exp = {4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0};
    n_vec++;
    if (got1 !== exp) begin
      n_err++;
      $display("FAIL init_reset got=%h exp=%h", got1, exp);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = {(k >= 7) ? 4'b0000 : 4'b1111, 4'b0000, (k == 7) ? 4'b1111 : 4'b0000,
             (k >= 3 && k <= 6) ? 4'b0000 : 4'b1111, 1'b0, k == 7};
      n_vec++;
      if (got1 !== exp) begin
        n_err++;
        $display("FAIL init_one k=%0d got=%h exp=%h", k, got1, exp);
      end
    end
  endtask

  initial begin
    if0.x = 4'b0000;
    test_reset();
    test_step();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_init_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel, parametrised key/switch debouncer for the board I/O front end, fed directly by buttons and switches.
- Each channel synchronises its raw input, filters bounces with a per-channel cycle counter, and outputs a clean level plus one-cycle rising/falling pulses.
- Bounce shorter than DELAY cycles is cancelled rather than accumulated.
- Replaces per-button single debouncers plus separate pulse timers with one bank feeding the CPU/IO control logic.

Parameters:
- CH, 5, number of independent channels (>=1).
- DELAY, 1000000, stable-cycle count required before a level change is accepted (>=1).
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2).
- INIT, 0, reset value of every channel's synchroniser stages and output level (1 bit, applied to all channels).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- x  in  CH  raw asynchronous inputs, one bit per channel.
- level  out  CH  debounced level per channel.
- pos  out  CH  one-cycle pulse when level goes 0->1.
- neg  out  CH  one-cycle pulse when level goes 1->0.
- stable  out  CH  1 when the channel is not mid-qualification.
- any_pos  out  1  OR of pos.
- any_neg  out  1  OR of neg.

Behaviour:
- All state updates on the rising edge of clk; no combinational path from x to any output.
- Reset (rst=1 at an edge):
  - synchroniser stages = INIT; level = INIT (all bits); pos = neg = 0; stable = all 1; counters = 0; all FSMs in STABLE.
  - Reset overrides everything else, including mid-qualification channels; no pulse is emitted on or after the reset edge.
- Per channel, s = last synchroniser stage, giving SYNC_STAGES cycles of input latency.
- Counter width is clog2(DELAY+1); it never wraps.
- Per-channel FSM, two states:
  - STABLE:
    - s == level: stay, cnt = 0.
    - s != level: go to WAIT, cnt <= 1.
  - WAIT, evaluated in this priority:
    1. s == level (bounce back): go to STABLE, cnt <= 0, level unchanged, no pulse.
    2. cnt == DELAY: level <= ~level, go to STABLE, cnt <= 0, and pos (new level 1) or neg (new level 0) <= 1 for that single cycle.
    3. Otherwise cnt <= cnt + 1.
- Timing:
  - If the entry edge into WAIT is edge k and s holds the new value through edge k+DELAY, level flips at edge k+DELAY.
  - Total latency from a clean x change to the level change is SYNC_STAGES + DELAY + 1 edges.
- Pulses:
  - pos/neg are registered and high exactly one cycle, coinciding with the first cycle of the new level.
  - pos and neg are never both high on the same channel.
  - A new level change needs at least DELAY+1 further cycles, so pulses on a channel are separated by at least DELAY+1 cycles.
- stable = (state == STABLE), registered.
- Channels are fully independent: simultaneous transitions on several channels each produce their own pulse in the same cycle, and any_pos/any_neg reflect the OR of those pulses.
- If x is held at ~INIT from reset onward, the channel debounces normally and emits one pos (or neg) after the latency above. This is required behaviour, not suppressed.
- A bounce that returns in WAIT resets qualification fully; there is no partial credit on re-entry.

Test Plan (CH=4, DELAY=4, SYNC_STAGES=2, INIT=0 unless noted):
1. Reset, then x=0000 for 20 cycles -> level=0000, pos=neg=0000, stable=1111 throughout.
2. Clean step x[0]: 0->1 at cycle 10, held -> stable[0]=0 from cycle 13; level[0]=1 and pos[0]=1 for exactly one cycle at cycle 17; any_pos=1 that cycle only; other channels untouched.
3. Bounce on x[1]: 1 for 3 cycles, 0 for 1, then 1 held -> no pulse on the first burst; stable[1] returns to 1; level[1] rises 5 cycles after the synchronised restart; exactly one pos[1].
4. Simultaneous step: x[2] 0->1 and x[3] 1->0 on the same cycle, with x[3] previously debounced high -> pos[2] and neg[3] asserted in the same cycle; any_pos=any_neg=1 for one cycle.
5. Reset mid-qualification: rst=1 while channel 0 is in WAIT with cnt=3 -> next cycle level[0]=0, stable[0]=1, no pulse; with x still 1, a full new qualification follows and pos[0] fires once.
6. INIT=1 with x=0000 held through reset -> level=1111 after reset; neg=1111 exactly once, SYNC_STAGES+DELAY+1 cycles after reset release.
